// File: rtl/seq_stage_ctrl.sv
// Sequencing controller for a multi-cycle Y86 datapath: steps one instruction through
// FETCH..PCUPD, tracks Y86 status and stops in HALT on fetch, decode or data-memory faults.
module seq_stage_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic [3:0]  icode,
  input  logic        instr_valid,
  input  logic        imem_error,
  input  logic        dmem_ack,
  input  logic        dmem_error,
  output logic        fetch_en,
  output logic        decode_en,
  output logic        exec_en,
  output logic        mem_en,
  output logic        wb_en,
  output logic        pc_en,
  output logic        cc_en,
  output logic        dmem_req,
  output logic [2:0]  stat,
  output logic        busy,
  output logic [31:0] instr_count
);

  typedef enum logic [2:0] {
    StIdle, StFetch, StDecode, StExecute, StMemory, StWriteback, StPcupd, StHalt
  } state_e;

  localparam logic [2:0] StatAok = 3'd1;
  localparam logic [2:0] StatHlt = 3'd2;
  localparam logic [2:0] StatAdr = 3'd3;
  localparam logic [2:0] StatIns = 3'd4;
  localparam logic [3:0] TimeoutCnt = 4'(MEM_TIMEOUT);

  state_e      r_state, w_state_next;
  logic [2:0]  r_stat, w_stat_next;
  logic [3:0]  r_icode, w_icode_next;
  logic [3:0]  r_wait_cnt, w_wait_cnt_next;
  logic [31:0] r_instr_count, w_instr_count_next;
  logic        w_mem_op;
  logic [3:0]  w_wait_inc;

  // rmmovq, mrmovq, call, ret, pushq, popq touch data memory
  assign w_mem_op   = r_icode inside {4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd11};
  assign w_wait_inc = r_wait_cnt + 4'd1;

  always_comb begin
    w_state_next       = r_state;
    w_stat_next        = r_stat;
    w_icode_next       = r_icode;
    w_wait_cnt_next    = r_wait_cnt;
    w_instr_count_next = r_instr_count;
    unique case (r_state)
      StIdle: if (start) w_state_next = StFetch;
      StFetch: begin
        w_icode_next = icode;
        if (imem_error) begin
          w_state_next = StHalt;
          w_stat_next  = StatAdr;
        end else if (!instr_valid || (icode > 4'd11)) begin
          w_state_next = StHalt;
          w_stat_next  = StatIns;
        end else if (icode == 4'd0) begin
          w_state_next = StHalt;
          w_stat_next  = StatHlt;
        end else begin
          w_state_next = StDecode;
        end
      end
      StDecode: w_state_next = StExecute;
      StExecute: begin
        w_state_next    = StMemory;
        w_wait_cnt_next = 4'd0;
      end
      StMemory: begin
        if (!w_mem_op) begin
          w_state_next = StWriteback;
        end else if (dmem_ack) begin
          // An ack in the timeout cycle still completes the access
          if (dmem_error) begin
            w_state_next = StHalt;
            w_stat_next  = StatAdr;
          end else begin
            w_state_next = StWriteback;
          end
        end else begin
          w_wait_cnt_next = w_wait_inc;
          if (w_wait_inc == TimeoutCnt) begin
            w_state_next = StHalt;
            w_stat_next  = StatAdr;
          end
        end
      end
      StWriteback: w_state_next = StPcupd;
      StPcupd: begin
        w_instr_count_next = r_instr_count + 32'd1;
        w_state_next       = stop ? StIdle : StFetch;
      end
      StHalt: w_state_next = StHalt;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= StIdle;
      r_stat        <= StatAok;
      r_icode       <= 4'd0;
      r_wait_cnt    <= 4'd0;
      r_instr_count <= 32'd0;
    end else begin
      r_state       <= w_state_next;
      r_stat        <= w_stat_next;
      r_icode       <= w_icode_next;
      r_wait_cnt    <= w_wait_cnt_next;
      r_instr_count <= w_instr_count_next;
    end
  end

  assign fetch_en    = (r_state == StFetch);
  assign decode_en   = (r_state == StDecode);
  assign exec_en     = (r_state == StExecute);
  assign mem_en      = (r_state == StMemory);
  assign wb_en       = (r_state == StWriteback);
  assign pc_en       = (r_state == StPcupd);
  assign cc_en       = (r_state == StExecute) && (r_icode == 4'd6);
  assign dmem_req    = (r_state == StMemory) && w_mem_op;
  assign busy        = (r_state != StIdle) && (r_state != StHalt);
  assign stat        = r_stat;
  assign instr_count = r_instr_count;

endmodule

// File: tb/tb_seq_stage_ctrl.sv
// Directed bench for seq_stage_ctrl: walks instructions through the stage sequence and
// compares enables, status and counts against hand-computed cycle numbers.
module tb_seq_stage_ctrl;

  logic        clk, rst, start, stop, instr_valid, imem_error, dmem_ack, dmem_error;
  logic [3:0]  icode;
  logic        fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en, cc_en, dmem_req, busy;
  logic [2:0]  stat;
  logic [31:0] instr_count;

  int n_total = 0;
  int n_bad   = 0;

  seq_stage_ctrl #(.MEM_TIMEOUT(15)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .icode       (icode),
    .instr_valid (instr_valid),
    .imem_error  (imem_error),
    .dmem_ack    (dmem_ack),
    .dmem_error  (dmem_error),
    .fetch_en    (fetch_en),
    .decode_en   (decode_en),
    .exec_en     (exec_en),
    .mem_en      (mem_en),
    .wb_en       (wb_en),
    .pc_en       (pc_en),
    .cc_en       (cc_en),
    .dmem_req    (dmem_req),
    .stat        (stat),
    .busy        (busy),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; icode = 4'd0; instr_valid = 1'b1;
    imem_error = 1'b0; dmem_ack = 1'b0; dmem_error = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Leaves the DUT in FETCH (cycle 1) with code presented
  task automatic begin_instr(input logic [3:0] code);
    icode = code; instr_valid = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // From cycle 1 (FETCH) runs until PCUPD or until busy drops; acks after ack_after waits.
  task automatic run_instr(input int ack_after, output int req_n, output int pc_cyc,
                           output int end_cyc, output logic [31:0] cc_mask);
    int waits;
    waits = 0; req_n = 0; pc_cyc = 0; end_cyc = 0; cc_mask = 32'd0;
    for (int c = 1; c <= 40; c++) begin
      if (cc_en) cc_mask[c] = 1'b1;
      if (dmem_req) begin
        req_n++;
        if (waits == ack_after) dmem_ack = 1'b1;
        else begin
          dmem_ack = 1'b0;
          waits++;
        end
      end
      if (pc_en) pc_cyc = c;
      if (pc_en || !busy) begin
        end_cyc = c;
        break;
      end
      step();
      dmem_ack = 1'b0;
    end
    dmem_ack = 1'b0;
    chk("run_bound", 32'(end_cyc != 0), 32'd1);
  endtask

  int          req_n, pc_cyc, end_cyc;
  logic [31:0] cc_mask;

  initial begin
    do_reset();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_stat", 32'(stat), 32'd1);
    chk("rst_cnt", instr_count, 32'd0);
    chk("rst_en", 32'({fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en, cc_en, dmem_req}),
        32'd0);
    step();
    chk("idle_hold", 32'(busy), 32'd0);

    // OPq: cc_en only in cycle 3, pc_en in cycle 6
    begin_instr(4'd6);
    chk("op_fetch", 32'(fetch_en), 32'd1);
    run_instr(-1, req_n, pc_cyc, end_cyc, cc_mask);
    chk("op_req", 32'(req_n), 32'd0);
    chk("op_pc", 32'(pc_cyc), 32'd6);
    chk("op_cc", cc_mask, 32'h8);
    chk("op_cnt_pc", instr_count, 32'd0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("op_stop_busy", 32'(busy), 32'd0);
    chk("op_cnt", instr_count, 32'd1);

    // mrmovq, ack after 3 waits: 4 request cycles, PCUPD in cycle 9
    begin_instr(4'd5);
    run_instr(3, req_n, pc_cyc, end_cyc, cc_mask);
    chk("mr_req", 32'(req_n), 32'd4);
    chk("mr_pc", 32'(pc_cyc), 32'd9);
    chk("mr_stat", 32'(stat), 32'd1);
    chk("mr_cc", cc_mask, 32'd0);
    step();
    chk("mr_refetch", 32'(fetch_en), 32'd1);
    chk("mr_cnt", instr_count, 32'd2);

    // popq, ack in the 15th request cycle beats the timeout
    icode = 4'd11;
    run_instr(14, req_n, pc_cyc, end_cyc, cc_mask);
    chk("tie_req", 32'(req_n), 32'd15);
    chk("tie_pc", 32'(pc_cyc), 32'd20);
    chk("tie_stat", 32'(stat), 32'd1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("tie_cnt", instr_count, 32'd3);

    // pushq, no ack: timeout after 15 waits
    begin_instr(4'd10);
    run_instr(99, req_n, pc_cyc, end_cyc, cc_mask);
    chk("to_req", 32'(req_n), 32'd15);
    chk("to_end", 32'(end_cyc), 32'd19);
    chk("to_pc", 32'(pc_cyc), 32'd0);
    chk("to_stat", 32'(stat), 32'd3);
    chk("to_busy", 32'(busy), 32'd0);
    chk("to_dreq", 32'(dmem_req), 32'd0);
    chk("to_cnt", instr_count, 32'd3);
    start = 1'b1;
    stop  = 1'b1;
    step();
    step();
    start = 1'b0;
    stop  = 1'b0;
    chk("halt_busy", 32'(busy), 32'd0);
    chk("halt_fetch", 32'(fetch_en), 32'd0);
    chk("halt_stat", 32'(stat), 32'd3);

    // call with data-memory error on the first ack
    do_reset();
    dmem_error = 1'b1;
    begin_instr(4'd8);
    run_instr(0, req_n, pc_cyc, end_cyc, cc_mask);
    dmem_error = 1'b0;
    chk("derr_req", 32'(req_n), 32'd1);
    chk("derr_end", 32'(end_cyc), 32'd5);
    chk("derr_stat", 32'(stat), 32'd3);
    chk("derr_cnt", instr_count, 32'd0);

    // Fetch-time faults: {icode, instr_valid, imem_error, stat}; stat 1 means DECODE
    begin
      logic [9:0] vec [6];
      vec[0] = {4'd0,  1'b1, 1'b0, 3'd2, 1'b0};
      vec[1] = {4'd13, 1'b1, 1'b0, 3'd4, 1'b0};
      vec[2] = {4'd0,  1'b1, 1'b1, 3'd3, 1'b0};
      vec[3] = {4'd3,  1'b0, 1'b0, 3'd4, 1'b0};
      vec[4] = {4'd12, 1'b1, 1'b0, 3'd4, 1'b0};
      vec[5] = {4'd11, 1'b1, 1'b0, 3'd1, 1'b1};
      for (int i = 0; i < 6; i++) begin
        do_reset();
        begin_instr(vec[i][9:6]);
        instr_valid = vec[i][5];
        imem_error  = vec[i][4];
        step();
        chk($sformatf("fx%0d_stat", i), 32'(stat), 32'(vec[i][3:1]));
        chk($sformatf("fx%0d_dec", i), 32'(decode_en), 32'(vec[i][0]));
        chk($sformatf("fx%0d_busy", i), 32'(busy), 32'(vec[i][0]));
      end
    end

    // Asynchronous reset while a memory request is outstanding
    do_reset();
    begin_instr(4'd9);
    step();
    step();
    step();
    chk("mid_req", 32'(dmem_req), 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("arst_req", 32'(dmem_req), 32'd0);
    chk("arst_mem", 32'(mem_en), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_stat", 32'(stat), 32'd1);
    step();
    rst = 1'b0;
    step();
    chk("arst_idle", 32'(busy), 32'd0);
    begin_instr(4'd6);
    chk("arst_restart", 32'(fetch_en), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_stage_ctrl.md
SEQ_STAGE_CTRL -- requirements
Module: seq_stage_ctrl

Interface
REQ-001 SHALL expose parameter MEM_TIMEOUT, default 15, memory-wait cycles before address fault.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  leave IDLE and begin fetching.
REQ-005 SHALL have port stop  input  1  return to IDLE after the current instruction.
REQ-006 SHALL have port icode  input  4  instruction code from fetch, valid in FETCH.
REQ-007 SHALL have port instr_valid  input  1  fetch decoded a legal ifun/format.
REQ-008 SHALL have port imem_error  input  1  fetch address fault, valid in FETCH.
REQ-009 SHALL have port dmem_ack  input  1  data-memory access complete.
REQ-010 SHALL have port dmem_error  input  1  data-memory fault, qualified by dmem_ack.
REQ-011 SHALL have ports fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en  output  1 each  stage enables.
REQ-012 SHALL have port cc_en  output  1  condition-code register write enable.
REQ-013 SHALL have port dmem_req  output  1  data-memory request.
REQ-014 SHALL have port stat  output  3  Y86 status: 1 AOK, 2 HLT, 3 ADR, 4 INS.
REQ-015 SHALL have port busy  output  1  high in any state except IDLE and HALT.
REQ-016 SHALL have port instr_count  output  32  retired-instruction count.

Function
REQ-017 SHALL implement states IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALT.
REQ-018 SHALL decode enables from the state register only: exactly one of fetch_en..pc_en high in the matching state, all low in IDLE/HALT.
REQ-019 SHALL go IDLE->FETCH when start=1, else remain in IDLE.
REQ-020 SHALL latch icode into icode_q at the end of FETCH.
REQ-021 SHALL, at the end of FETCH, apply priority: imem_error -> HALT, stat=3; else !instr_valid or icode>11 -> HALT, stat=4; else icode==0 -> HALT, stat=2; else -> DECODE.
REQ-022 SHALL advance DECODE->EXECUTE->MEMORY unconditionally, one cycle each.
REQ-023 SHALL assert cc_en only in EXECUTE with icode_q==6 (OPq).
REQ-024 SHALL assert dmem_req in MEMORY for icode_q in {4,5,8,9,10,11}; it is held high until dmem_ack.
REQ-025 SHALL leave MEMORY after one cycle for non-memory icodes.
REQ-026 SHALL leave MEMORY for memory icodes on the first cycle with dmem_ack=1: dmem_error=1 -> HALT, stat=3; else -> WRITEBACK.
REQ-027 SHALL count wait cycles (dmem_req=1, dmem_ack=0) in a 4-bit counter cleared on MEMORY entry; on reaching MEM_TIMEOUT -> HALT, stat=3.
REQ-028 SHALL let dmem_ack take precedence over a timeout in the same cycle.
REQ-029 SHALL go WRITEBACK->PCUPD unconditionally; skipped writeback or PC update on any fault is required.
REQ-030 SHALL, at the end of PCUPD, increment instr_count (wrapping 0xFFFFFFFF->0) and go to IDLE if stop=1, else to FETCH.
REQ-031 SHALL leave HALT only via rst, ignoring start and stop; stat holds the fault code.
REQ-032 SHALL give a latency of 6 cycles FETCH-to-PCUPD inclusive for zero-wait instructions, plus 1 per wait cycle.

Reset
REQ-033 SHALL on rst=1, regardless of clk, force state=IDLE, stat=1, instr_count=0, icode_q=0, wait counter=0, all enables/dmem_req/busy=0.
REQ-034 SHALL abort an in-flight instruction on rst mid-MEMORY without dmem_req held after reset, and resume only on a new start.

Verification
REQ-035 SHALL cover: start with icode=6, valid -> cc_en high exactly in cycle 3, pc_en in cycle 6, instr_count=1.
REQ-036 SHALL cover: icode=5 with dmem_ack after 3 wait cycles -> dmem_req high 4 cycles, pc_en in cycle 9, stat=1.
REQ-037 SHALL cover: icode=10 with no ack -> after 15 wait cycles HALT, stat=3, busy=0, instr_count unchanged.
REQ-038 SHALL cover: icode=0 -> HALT after FETCH, stat=2; icode=13 -> stat=4; imem_error with icode=0 -> stat=3.
REQ-039 SHALL cover: stop=1 during PCUPD -> IDLE, busy=0; start=1 in HALT -> no change.
REQ-040 SHALL cover: rst asserted mid-MEMORY between edges -> outputs zero immediately, stat=1, state IDLE.
